// File: rtl/multiword_adder_ctrl_if.sv
// Handshake and adder-side signal bundle for multiword_adder_ctrl.
// MWADD_SUB_EN adds the sub_i operand qualifier.
interface multiword_adder_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int NBWORDS  = 4
);
  localparam int W = DATASIZE * NBWORDS;

  logic                in_valid_i;
  logic                in_ready_o;
  logic [W-1:0]        op_a_i;
  logic [W-1:0]        op_b_i;
  logic                carry_in_i;
`ifdef MWADD_SUB_EN
  logic                sub_i;
`endif
  logic [DATASIZE-1:0] add_a_o;
  logic [DATASIZE-1:0] add_b_o;
  logic                add_carry_o;
  logic [DATASIZE-1:0] add_result_i;
  logic                add_carry_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [W-1:0]        sum_o;
  logic                carry_o;

`ifdef MWADD_SUB_EN
  modport slave (
    input  in_valid_i, op_a_i, op_b_i, carry_in_i, sub_i,
           add_result_i, add_carry_i, out_ready_i,
    output in_ready_o, add_a_o, add_b_o, add_carry_o,
           out_valid_o, sum_o, carry_o
  );
  modport master (
    output in_valid_i, op_a_i, op_b_i, carry_in_i, sub_i,
           add_result_i, add_carry_i, out_ready_i,
    input  in_ready_o, add_a_o, add_b_o, add_carry_o,
           out_valid_o, sum_o, carry_o
  );
`else
  modport slave (
    input  in_valid_i, op_a_i, op_b_i, carry_in_i,
           add_result_i, add_carry_i, out_ready_i,
    output in_ready_o, add_a_o, add_b_o, add_carry_o,
           out_valid_o, sum_o, carry_o
  );
  modport master (
    output in_valid_i, op_a_i, op_b_i, carry_in_i,
           add_result_i, add_carry_i, out_ready_i,
    input  in_ready_o, add_a_o, add_b_o, add_carry_o,
           out_valid_o, sum_o, carry_o
  );
`endif
endinterface

// File: rtl/multiword_adder_ctrl.sv
// Word-serial controller driving an external DATASIZE-bit adder, LSW first,
// with valid/ready on both sides. Define MWADD_SUB_EN to enable subtraction.
module multiword_adder_ctrl #(
  parameter int DATASIZE = 8,
  parameter int NBWORDS  = 4
) (
  input logic                    clk_i,
  input logic                    rst_i,
  multiword_adder_ctrl_if.slave  bus
);
  localparam int W     = DATASIZE * NBWORDS;
  localparam int IDX_W = (NBWORDS > 1) ? $clog2(NBWORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    idx;
  logic [W-1:0]        op_a_q, op_b_q;
  logic [W-1:0]        work_q, work_next;
  logic [W-1:0]        sum_q;
  logic                carry_q;
  logic                cout_q;
  logic                last_word;
  logic                accept;
  logic                init_carry;
  logic [DATASIZE-1:0] b_word;
`ifdef MWADD_SUB_EN
  logic                sub_q;
`endif

  assign last_word = (idx == IDX_W'(NBWORDS - 1));
  assign accept    = (state == IDLE) && bus.in_valid_i;

  // Subtraction is A + ~B + 1, so the inverted word and forced carry-in are all it takes.
`ifdef MWADD_SUB_EN
  assign init_carry = bus.sub_i ? 1'b1 : bus.carry_in_i;
  assign b_word     = sub_q ? ~op_b_q[int'(idx)*DATASIZE +: DATASIZE]
                            :  op_b_q[int'(idx)*DATASIZE +: DATASIZE];
`else
  assign init_carry = bus.carry_in_i;
  assign b_word     = op_b_q[int'(idx)*DATASIZE +: DATASIZE];
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid_i)  state_next = RUN;
      RUN:     if (last_word)       state_next = DONE;
      DONE:    if (bus.out_ready_i) state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready_o  = (state == IDLE) && !rst_i;
    bus.out_valid_o = (state == DONE);
    bus.add_a_o     = '0;
    bus.add_b_o     = '0;
    bus.add_carry_o = 1'b0;
    if (state == RUN) begin
      bus.add_a_o     = op_a_q[int'(idx)*DATASIZE +: DATASIZE];
      bus.add_b_o     = b_word;
      bus.add_carry_o = carry_q;
    end
  end

  // Partial sums accumulate in work_q; sum_q only changes on entry to DONE,
  // so the visible result holds until the next operation completes.
  always_comb begin
    work_next = work_q;
    work_next[int'(idx)*DATASIZE +: DATASIZE] = bus.add_result_i;
  end

  // NOTE: the operand and result registers are reset too; the register file is
  // tiny and a reset-abort must leave every output at its reset value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx     <= '0;
`ifdef MWADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else if (accept) begin
      op_a_q  <= bus.op_a_i;
      op_b_q  <= bus.op_b_i;
      carry_q <= init_carry;
      idx     <= '0;
`ifdef MWADD_SUB_EN
      sub_q   <= bus.sub_i;
`endif
    end else if (state == RUN) begin
      work_q  <= work_next;
      carry_q <= bus.add_carry_i;
      if (last_word) begin
        idx    <= '0;
        sum_q  <= work_next;
        cout_q <= bus.add_carry_i;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign bus.sum_o   = sum_q;
  assign bus.carry_o = cout_q;

endmodule
